// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: stall/redirect/bubble/forwarding control with a RUN/FREEZE data-memory FSM; HAZARD_PERF_EN adds stall/kill counters
module fetch_hazard_ctrl #(
    parameter int RN_W   = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [RN_W-1:0]   id_rs,
    input  logic [RN_W-1:0]   id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [1:0]        pcsource_i,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [RN_W-1:0]   ex_rn,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [RN_W-1:0]   mem_rn,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [1:0]        pcsource_o,
    output logic              if_kill,
    output logic              id_bubble,
    output logic              pipe_hold,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_kill
);
    typedef enum logic {RUN, FREEZE} state_t;
    state_t state, state_nx;
    logic hold, lu, ex_fa, ex_fb, mem_fa, mem_fb;

    always_ff @(posedge clk)
        state <= clrn ? RUN : state_nx;

    always_comb
        state_nx = (state == FREEZE) ? (dmem_ack ? RUN : FREEZE)
                                     : ((dmem_req && !dmem_ack) ? FREEZE : RUN);

    assign hold   = (state == FREEZE) || (dmem_req && !dmem_ack);
    assign lu     = ex_wreg && ex_m2reg && ex_rn != '0 &&
                    ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));
    assign ex_fa  = ex_wreg && !ex_m2reg && ex_rn != '0 && ex_rn == id_rs;
    assign ex_fb  = ex_wreg && !ex_m2reg && ex_rn != '0 && ex_rn == id_rt;
    assign mem_fa = mem_wreg && mem_rn != '0 && mem_rn == id_rs;
    assign mem_fb = mem_wreg && mem_rn != '0 && mem_rn == id_rt;

    always_comb begin
        stall      = 1'b0;
        pipe_hold  = 1'b0;
        id_bubble  = 1'b0;
        if_kill    = 1'b0;
        pcsource_o = 2'b00;
        fwda       = 2'b00;
        fwdb       = 2'b00;
        if (!clrn) begin
            stall      = hold || lu;
            pipe_hold  = hold;
            id_bubble  = !hold && lu;
            if_kill    = !hold && !lu && pcsource_i != 2'b00;
            pcsource_o = (!hold && !lu) ? pcsource_i : 2'b00;
            fwda       = ex_fa ? 2'b01 : mem_fa ? {1'b1, mem_m2reg} : 2'b00;
            fwdb       = ex_fb ? 2'b01 : mem_fb ? {1'b1, mem_m2reg} : 2'b00;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        perf_stall <= clrn ? '0 : perf_stall + PERF_W'(stall);
        perf_kill  <= clrn ? '0 : perf_kill + PERF_W'(if_kill);
    end
`else
    assign perf_stall = '0;
    assign perf_kill  = '0;
`endif
endmodule
